// File: rtl/cargador_ordenamiento.sv
// Front end for the 16-entry sort array: turns button presses into write strobes,
// then fires the sort strobe and steps the read-out positions with show strobes.
module cargador_ordenamiento #(
    parameter int N        = 16,
    parameter int DATA_W   = 5,
    parameter int ORD_WAIT = 4,
    parameter int SHOW_DIV = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] dato,
    input  logic              boton,
    input  logic              limpiar,
    output logic [DATA_W-1:0] dato_o,
    output logic [3:0]        pos,
    output logic              almacenar,
    output logic              ordenar,
    output logic              show,
    output logic [4:0]        cuenta,
    output logic              listo,
    output logic [2:0]        estado
);

    // Handshake-free strobe protocol: each strobe is a one-cycle pulse, and pos/dato_o
    // are settled at least one cycle before any strobe and held while it is high.

    localparam int CNT_W = $clog2((SHOW_DIV > ORD_WAIT) ? SHOW_DIV : ORD_WAIT) + 1;
    localparam logic [4:0]       ULTIMO   = 5'(N - 1);
    localparam logic [CNT_W-1:0] FIN_ESP  = CNT_W'(ORD_WAIT - 1);
    localparam logic [CNT_W-1:0] FIN_HOLD = CNT_W'(SHOW_DIV - 1);

    typedef enum logic [2:0] {
        CARGA    = 3'd0,
        CAPTURA  = 3'd1,
        ALMACENA = 3'd2,
        ORDENA   = 3'd3,
        ESPERA   = 3'd4,
        MUESTRA  = 3'd5,
        FIN      = 3'd6
    } estado_t;

    estado_t           state_q, state_d;
    logic              s1, s2, s3;
    logic              pulsacion;
    logic [DATA_W-1:0] dato_q, dato_d;
    logic [3:0]        pos_q, pos_d;
    logic              alm_q, alm_d;
    logic              ord_q, ord_d;
    logic              show_q, show_d;
    logic [4:0]        cuenta_q, cuenta_d;
    logic              listo_q, listo_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Rising edge of the synchronised button; s3 is the previous s2.
    assign pulsacion = s2 & ~s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            s3       <= 1'b0;
            state_q  <= CARGA;
            dato_q   <= '0;
            pos_q    <= '0;
            alm_q    <= 1'b0;
            ord_q    <= 1'b0;
            show_q   <= 1'b0;
            cuenta_q <= '0;
            listo_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1       <= boton;
            s2       <= s1;
            s3       <= s2;
            state_q  <= state_d;
            dato_q   <= dato_d;
            pos_q    <= pos_d;
            alm_q    <= alm_d;
            ord_q    <= ord_d;
            show_q   <= show_d;
            cuenta_q <= cuenta_d;
            listo_q  <= listo_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        dato_d   = dato_q;
        pos_d    = pos_q;
        alm_d    = 1'b0;
        ord_d    = 1'b0;
        show_d   = 1'b0;
        cuenta_d = cuenta_q;
        listo_d  = listo_q;
        cnt_d    = cnt_q;

        if (limpiar) begin
            // dato_o is deliberately left untouched.
            state_d  = CARGA;
            pos_d    = '0;
            cuenta_d = '0;
            listo_d  = 1'b0;
            cnt_d    = '0;
        end else begin
            case (state_q)
                CARGA: begin
                    if (pulsacion) begin
                        dato_d  = dato;
                        pos_d   = cuenta_q[3:0];
                        state_d = CAPTURA;
                    end
                end
                CAPTURA: begin
                    alm_d   = 1'b1;
                    state_d = ALMACENA;
                end
                ALMACENA: begin
                    cuenta_d = cuenta_q + 5'd1;
                    if (cuenta_q == ULTIMO) begin
                        state_d = ORDENA;
                        cnt_d   = '0;
                    end else begin
                        state_d = CARGA;
                    end
                end
                ORDENA: begin
                    // First cycle is a spacer after almacenar; the pulse occupies the second.
                    if (cnt_q == '0) begin
                        ord_d = 1'b1;
                        cnt_d = CNT_W'(1);
                    end else begin
                        state_d = ESPERA;
                        cnt_d   = '0;
                    end
                end
                ESPERA: begin
                    if (cnt_q == FIN_ESP) begin
                        state_d = MUESTRA;
                        pos_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                MUESTRA: begin
                    show_d = (cnt_q == '0);
                    if (cnt_q == FIN_HOLD) begin
                        cnt_d = '0;
                        if (pos_q == 4'd15) begin
                            state_d = FIN;
                            listo_d = 1'b1;
                        end else begin
                            pos_d = pos_q + 4'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                FIN: begin
                    listo_d = 1'b1;
                end
                default: begin
                    state_d = CARGA;
                end
            endcase
        end
    end

    assign dato_o    = dato_q;
    assign pos       = pos_q;
    assign almacenar = alm_q;
    assign ordenar   = ord_q;
    assign show      = show_q;
    assign cuenta    = cuenta_q;
    assign listo     = listo_q;
    assign estado    = state_q;

endmodule

// File: tb/tb_cargador_ordenamiento.sv
// Bench for cargador_ordenamiento: timeline model of expected outputs per clock edge,
// per-cycle compare, strobe hygiene monitor and a downstream sort-array model.
module tb_cargador_ordenamiento;

    localparam int DATA_W   = 5;
    localparam int ORD_WAIT = 4;
    localparam int SHOW_DIV = 8;
    localparam int MAXC     = 3000;
    localparam logic [2:0] EST_CARGA = 3'd0;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] dato = '0;
    logic              boton = 1'b0;
    logic              limpiar = 1'b0;
    logic [DATA_W-1:0] dato_o;
    logic [3:0]        pos;
    logic              almacenar, ordenar, show, listo;
    logic [4:0]        cuenta;
    logic [2:0]        estado;

    always #5 clk = ~clk;

    cargador_ordenamiento #(
        .N(16), .DATA_W(DATA_W), .ORD_WAIT(ORD_WAIT), .SHOW_DIV(SHOW_DIV)
    ) dut (
        .clk(clk), .rst(rst), .dato(dato), .boton(boton), .limpiar(limpiar),
        .dato_o(dato_o), .pos(pos), .almacenar(almacenar), .ordenar(ordenar),
        .show(show), .cuenta(cuenta), .listo(listo), .estado(estado)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- timeline model: expected outputs after each edge ----------------
    logic [4:0] e_dato[MAXC];
    logic [3:0] e_pos[MAXC];
    logic [4:0] e_cuenta[MAXC];
    bit         e_listo[MAXC];
    bit         e_alm[MAXC];
    bit         e_ord[MAXC];
    bit         e_show[MAXC];

    function automatic void set_dato(int n, logic [4:0] v);
        for (int m = n; m < MAXC; m++) e_dato[m] = v;
    endfunction
    function automatic void set_pos(int n, logic [3:0] v);
        for (int m = n; m < MAXC; m++) e_pos[m] = v;
    endfunction
    function automatic void set_cuenta(int n, logic [4:0] v);
        for (int m = n; m < MAXC; m++) e_cuenta[m] = v;
    endfunction
    function automatic void set_listo(int n, bit v);
        for (int m = n; m < MAXC; m++) e_listo[m] = v;
    endfunction
    function automatic void clear_strobes(int n);
        for (int m = n; m < MAXC; m++) begin
            e_alm[m] = 1'b0; e_ord[m] = 1'b0; e_show[m] = 1'b0;
        end
    endfunction

    int cyc = -1;
    bit m_s1 = 0, m_s2 = 0, m_s3 = 0;
    int cuenta_m = 0;
    bit cargado = 0;
    int libre_desde = 0;

    always @(posedge clk) begin
        bit det;
        int t0;
        cyc++;
        if (cyc < MAXC - 400) begin
            if (rst) begin
                set_dato(cyc, 5'd0); set_pos(cyc, 4'd0); set_cuenta(cyc, 5'd0);
                set_listo(cyc, 1'b0); clear_strobes(cyc);
                m_s1 = 0; m_s2 = 0; m_s3 = 0;
                cuenta_m = 0; cargado = 0; libre_desde = 0;
            end else begin
                det = m_s2 & ~m_s3;
                m_s3 = m_s2; m_s2 = m_s1; m_s1 = boton;
                if (limpiar) begin
                    set_pos(cyc, 4'd0); set_cuenta(cyc, 5'd0); set_listo(cyc, 1'b0);
                    clear_strobes(cyc);
                    cuenta_m = 0; cargado = 0; libre_desde = cyc + 1;
                end else if (det && !cargado && cyc >= libre_desde) begin
                    // Accepted press: capture now, strobe next edge, count the edge after.
                    set_dato(cyc, dato);
                    set_pos(cyc, 4'(cuenta_m));
                    e_alm[cyc + 1] = 1'b1;
                    set_cuenta(cyc + 2, 5'(cuenta_m + 1));
                    libre_desde = cyc + 3;
                    cuenta_m++;
                    if (cuenta_m == 16) begin
                        cargado = 1;
                        e_ord[cyc + 3] = 1'b1;
                        t0 = cyc + 4 + ORD_WAIT;
                        for (int k = 0; k < 16; k++) begin
                            set_pos(t0 + k * SHOW_DIV, 4'(k));
                            e_show[t0 + k * SHOW_DIV + 1] = 1'b1;
                        end
                        set_listo(t0 + 16 * SHOW_DIV, 1'b1);
                    end
                end
            end
        end
    end

    // ---------------- compare, hygiene monitor, downstream array ----------------
    logic [4:0] arr[16];
    logic [4:0] read_q[$];
    logic [4:0] exp_q[$];
    logic [3:0] prev_pos;
    logic [4:0] prev_dato;
    int alm_count = 0, ord_count = 0, show_count = 0;

    always @(negedge clk) begin
        logic [4:0] tmp;
        if (cyc >= 0 && cyc < MAXC) begin
            check("dato_o", 32'(dato_o), 32'(e_dato[cyc]));
            check("pos", 32'(pos), 32'(e_pos[cyc]));
            check("almacenar", 32'(almacenar), 32'(e_alm[cyc]));
            check("ordenar", 32'(ordenar), 32'(e_ord[cyc]));
            check("show", 32'(show), 32'(e_show[cyc]));
            check("cuenta", 32'(cuenta), 32'(e_cuenta[cyc]));
            check("listo", 32'(listo), 32'(e_listo[cyc]));
            check("strobes_exclusivos",
                  32'((int'(almacenar) + int'(ordenar) + int'(show)) <= 1), 32'd1);
            if (almacenar || ordenar || show) begin
                check("pos_estable", 32'(pos), 32'(prev_pos));
                check("dato_estable", 32'(dato_o), 32'(prev_dato));
            end
            if (almacenar) begin
                arr[pos] = dato_o;
                alm_count++;
            end
            if (ordenar) begin
                ord_count++;
                for (int i = 0; i < 16; i++)
                    for (int j = 0; j < 15 - i; j++)
                        if (arr[j] > arr[j + 1]) begin
                            tmp = arr[j]; arr[j] = arr[j + 1]; arr[j + 1] = tmp;
                        end
            end
            if (show) begin
                show_count++;
                read_q.push_back(arr[pos]);
            end
        end
        prev_pos  = pos;
        prev_dato = dato_o;
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int k);
        repeat (k) @(negedge clk);
        #1;
    endtask

    task automatic press(input logic [4:0] v, input int hold, input int low);
        dato  = v;
        boton = 1'b1;
        step(hold);
        boton = 1'b0;
        step(low);
    endtask

    task automatic load16(input int last_low);
        for (int i = 0; i < 16; i++) press(5'(15 - i), 2, (i == 15) ? last_low : 6);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dato_o"}, 32'(dato_o), 32'd0);
        check({tag, "_pos"}, 32'(pos), 32'd0);
        check({tag, "_almacenar"}, 32'(almacenar), 32'd0);
        check({tag, "_ordenar"}, 32'(ordenar), 32'd0);
        check({tag, "_show"}, 32'(show), 32'd0);
        check({tag, "_cuenta"}, 32'(cuenta), 32'd0);
        check({tag, "_listo"}, 32'(listo), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int t, a0;
        for (int i = 0; i < 16; i++) arr[i] = '0;
        step(3);
        check_all_zero("reset");
        check("reset_estado", 32'(estado), 32'(EST_CARGA));
        rst = 1'b0;
        step(2);

        // Single store with hand-computed edge timing.
        dato = 5'd21; boton = 1'b1;
        step(1);                                   // E0
        step(1);                                   // E1
        step(1);                                   // E2
        check("e2_dato_o", 32'(dato_o), 32'd21);
        check("e2_pos", 32'(pos), 32'd0);
        check("e2_almacenar", 32'(almacenar), 32'd0);
        step(1);                                   // E3
        check("e3_almacenar", 32'(almacenar), 32'd1);
        boton = 1'b0;
        step(1);                                   // E4
        check("e4_almacenar", 32'(almacenar), 32'd0);
        check("e4_cuenta", 32'(cuenta), 32'd1);
        step(4);

        // Long hold gives one strobe only.
        press(5'd9, 12, 6);
        check("hold_cuenta", 32'(cuenta), 32'd2);
        check("hold_alm_count", 32'(alm_count), 32'd2);

        // Second detection two cycles after the first lands mid-store and is dropped.
        dato = 5'd3; boton = 1'b1; step(1);
        boton = 1'b0; step(1);
        boton = 1'b1; step(1);
        boton = 1'b0; step(8);
        check("close_cuenta", 32'(cuenta), 32'd3);
        check("close_alm_count", 32'(alm_count), 32'd3);

        // limpiar, then limpiar coincident with a detected press.
        limpiar = 1'b1; step(1); limpiar = 1'b0;
        check("limpiar_cuenta", 32'(cuenta), 32'd0);
        check("limpiar_pos", 32'(pos), 32'd0);
        check("limpiar_dato_kept", 32'(dato_o), 32'd3);
        step(2);
        dato = 5'd30; boton = 1'b1; step(1);      // E0
        boton = 1'b0; step(1);                     // E1: press visible
        limpiar = 1'b1; step(1); limpiar = 1'b0;   // E2: clear wins
        step(6);
        check("coinc_alm_count", 32'(alm_count), 32'd3);
        check("coinc_cuenta", 32'(cuenta), 32'd0);

        // Full load 15..0, presses during ESPERA and MUESTRA are ignored.
        read_q.delete();
        a0 = alm_count;
        load16(3);
        boton = 1'b1; step(1); boton = 1'b0;       // detected in ESPERA
        step(20);
        press(5'd7, 2, 6);                         // during MUESTRA
        check("load_cuenta", 32'(cuenta), 32'd16);
        check("load_alm_count", 32'(alm_count - a0), 32'd16);
        t = 0;
        while (!listo && t < 400) begin step(1); t++; end
        check("listo_reached", 32'(listo), 32'd1);
        check("fin_pos", 32'(pos), 32'd15);
        check("ord_count", 32'(ord_count), 32'd1);
        check("show_count", 32'(show_count), 32'd16);
        for (int i = 0; i < 16; i++) exp_q.push_back(5'(i));
        check("read_count", 32'(read_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < 16 && i < read_q.size(); i++)
            check("read_value", 32'(read_q[i]), 32'(exp_q[i]));
        step(5);

        // limpiar during read-out at position 7.
        limpiar = 1'b1; step(1); limpiar = 1'b0; step(2);
        load16(6);
        t = 0;
        while (!(show && pos == 4'd7) && t < 400) begin step(1); t++; end
        check("pos7_reached", 32'(pos), 32'd7);
        limpiar = 1'b1; step(1); limpiar = 1'b0;
        check("clr_estado", 32'(estado), 32'(EST_CARGA));
        check("clr_pos", 32'(pos), 32'd0);
        check("clr_cuenta", 32'(cuenta), 32'd0);
        check("clr_show", 32'(show), 32'd0);
        step(12);
        check("clr_no_listo", 32'(listo), 32'd0);

        // Asynchronous reset while almacenar is high.
        press(5'd1, 2, 6);
        dato = 5'd2; boton = 1'b1;
        step(4);                                   // E3: strobe high
        check("pre_rst_almacenar", 32'(almacenar), 32'd1);
        rst = 1'b1; boton = 1'b0;
        #1;
        check_all_zero("async_rst");
        step(3);
        rst = 1'b0;
        step(2);
        dato = 5'd4; boton = 1'b1;
        step(4);                                   // E3 after release
        check("post_rst_almacenar", 32'(almacenar), 32'd1);
        check("post_rst_pos", 32'(pos), 32'd0);
        check("post_rst_dato", 32'(dato_o), 32'd4);
        boton = 1'b0;
        step(6);
        check("post_rst_cuenta", 32'(cuenta), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #25000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
